rip_axi_arbiter: RTL and testbench
==================================

# rip_axi_arbiter

Two-to-one AXI4 master arbiter that lets two requesters (typically the pseudo-core's MMU page walker on port 0 and its data/DMA engine on port 1) share the single AXI4 master port leaving the PL. Read and write paths are arbitrated independently, each round-robin, with one outstanding transaction per path. The block sits between the requester interfaces and the board-level wrapper that exposes the flat AXI signals.

## Interface
- ID_WIDTH, 4, AXI ID width; IDs pass through unchanged.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; WSTRB is DATA_WIDTH/8.
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- S0  rip_axi_interface slave modport  —  requester 0, all five AXI channels.
- S1  rip_axi_interface slave modport  —  requester 1, all five AXI channels.
- M  rip_axi_interface master modport  —  shared downstream AXI4 master.
- rd_owner  out  2  one-hot read-path owner, bit0 = S0, 00 when idle.
- wr_owner  out  2  one-hot write-path owner, same encoding.

## Operation
- Read FSM states: RD_IDLE, RD_ADDR, RD_DATA.
  - RD_IDLE: if any ARVALID, grant per round-robin, register owner, go to RD_ADDR.
  - RD_ADDR: owner's AR channel is connected to M. On M.ARVALID&&M.ARREADY, go to RD_DATA.
  - RD_DATA: M's R channel is routed to the owner. On RVALID&&RREADY&&RLAST, return to RD_IDLE and update the last-grant pointer.
- Write FSM states: WR_IDLE, WR_XFER, WR_RESP.
  - WR_IDLE: grant on AWVALID only; a lone WVALID does not request.
  - WR_XFER: owner's AW and W channels are connected to M. Flags aw_done and w_done are set on the AW handshake and on the W handshake with WLAST; the two may complete in either order or in the same cycle. When both are set, go to WR_RESP.
  - WR_RESP: B is routed to the owner. On BVALID&&BREADY, return to WR_IDLE and update the pointer.
- Round-robin rule:
  - Both requesting: grant the port not granted last.
  - One requesting: grant it.
  - Read and write pointers are separate.
- Non-owner port sees ARREADY/AWREADY/WREADY = 0 and RVALID/BVALID = 0. Its R/B payload outputs are driven 0.
- Unused M valids are 0. Payloads are muxed from the owner; an idle FSM drives 0.
- M.WID is driven with the owner's AWID, latched at grant.
- Response codes (RRESP/BRESP, including SLVERR/DECERR) are forwarded unmodified.

## Timing
- Reset values:
  - Both FSMs idle; rd_owner = wr_owner = 00; pointers set so S0 wins the first tie.
  - All M valids and all S readies/valids = 0.
- Arbitration latency: one cycle. An ARVALID/AWVALID seen in IDLE appears on M the following cycle.
- No bubbles on the data path: in RD_ADDR, RD_DATA and WR_XFER, valid/ready/payload are combinational pass-through.
- Next-grant latency: after RLAST or the B handshake, the FSM is in IDLE for one cycle and the next grant is visible one cycle later. Back-to-back grants therefore have a 2-cycle gap.
- Requesters must hold VALID until handshake (AXI rule), so the grant never changes under a pending beat.
- Simultaneous read and write from different or the same ports proceed concurrently and independently.
- A burst of any length (ARLEN/AWLEN 0..255) holds the grant until its last beat. The arbiter does not count beats; it relies on RLAST/WLAST.
- Reset mid-transaction: all state clears asynchronously and outputs return to reset values at once. Recovering the downstream slave is the system's responsibility.

## Structure
- rip_axi_arb_pkg holds:
  - rd_state_t and wr_state_t enums;
  - NUM_PORTS = 2;
  - a one-hot owner typedef.
- One sub-module is natural: rip_rr_arbiter_2, holding the request → grant logic and the last-grant pointer, with an update strobe. It is instantiated once for read and once for write.
- Channel muxing stays in the top module.

## Test plan
- Single read: S0 issues ARADDR=0x1000, ARLEN=3.
  - M.ARVALID rises 1 cycle later with the same address.
  - The 4 R beats reach S0 with RLAST on beat 4; rd_owner returns to 00.
- Tie: S0 and S1 both assert ARVALID in the same cycle from reset.
  - S0 is served first, then S1 (ARADDR 0x2000) with a 2-cycle gap.
  - A repeated tie grants S1 first.
- Write, W before AW: S1 presents WDATA=0xDEADBEEF with WLAST one cycle before the AW handshake (AWADDR=0x3000).
  - Both handshakes complete on M with WID = AWID.
  - BRESP=OKAY reaches S1 only; S0 sees BVALID=0 throughout.
- Concurrency: S0 write and S1 read start in the same cycle.
  - Both proceed with overlapping beats and no cross-routing of R/B.
- Error forwarding: slave returns RRESP=SLVERR on beat 2 of a 4-beat burst.
  - The error is passed through, and the grant is held until RLAST.
- Reset mid-burst: deassert rstn during RD_DATA beat 2.
  - All outputs go to reset values immediately.
  - A new S1 read after reset is granted normally.

Source files
------------

// File: rtl/rip_axi_arb_pkg.sv
// Shared types for the two-port AXI4 arbiter: FSM state enums and the one-hot owner encoding.
package rip_axi_arb_pkg;

  localparam int NUM_PORTS = 2;

  // One-hot owner: bit0 = requester 0, bit1 = requester 1, all-zero = no owner.
  typedef logic [NUM_PORTS-1:0] owner_t;

  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_S0   = 2'b01;
  localparam owner_t OWN_S1   = 2'b10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_XFER,
    WR_RESP
  } wr_state_t;

endpackage

// File: rtl/rip_axi_interface.sv
// AXI4 bundle (with an AXI3-style WID) shared by requesters and the downstream master port.
interface rip_axi_interface #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/rip_rr_arbiter_2.sv
// Two-way round-robin grant logic with a last-grant pointer updated on transaction completion.
module rip_rr_arbiter_2
  import rip_axi_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic [NUM_PORTS-1:0] req,
  input  logic   update,
  input  owner_t upd_owner,
  output owner_t grant
);

  owner_t last_reg;

  // Pointer starts at port 1 so port 0 wins the first tie; moves to the finishing owner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_reg <= OWN_S1;
    end else if (update) begin
      last_reg <= upd_owner;
    end
  end

  // Combinational grant: on a tie, favour the port that was not granted last.
  always_comb begin
    grant = OWN_NONE;
    if (req == 2'b11) begin
      grant = (last_reg == OWN_S0) ? OWN_S1 : OWN_S0;
    end else if (req[0]) begin
      grant = OWN_S0;
    end else if (req[1]) begin
      grant = OWN_S1;
    end
  end

endmodule

// File: rtl/rip_axi_arbiter.sv
// Two-to-one AXI4 master arbiter: independent round-robin read and write paths,
// one outstanding transaction each, combinational channel pass-through once granted.
module rip_axi_arbiter
  import rip_axi_arb_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  rip_axi_interface.slave  S0,
  rip_axi_interface.slave  S1,
  rip_axi_interface.master M,
  output owner_t           rd_owner,
  output owner_t           wr_owner
);

  rd_state_t rd_state_reg, rd_state_next;
  owner_t    rd_owner_reg, rd_owner_next;
  owner_t    rd_grant;
  logic      rd_upd;

  wr_state_t wr_state_reg, wr_state_next;
  owner_t    wr_owner_reg, wr_owner_next;
  owner_t    wr_grant;
  logic      wr_upd;
  logic      aw_done_reg, aw_done_next;
  logic      w_done_reg, w_done_next;
  logic [ID_WIDTH-1:0] wid_reg, wid_next;

  logic rd_sel1;
  logic wr_sel1;

  // Owners are one-hot whenever a path is busy, so bit1 alone selects the port.
  assign rd_sel1  = rd_owner_reg[1];
  assign wr_sel1  = wr_owner_reg[1];
  assign rd_owner = rd_owner_reg;
  assign wr_owner = wr_owner_reg;

  rip_rr_arbiter_2 u_rd_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       ({S1.arvalid, S0.arvalid}),
    .update    (rd_upd),
    .upd_owner (rd_owner_reg),
    .grant     (rd_grant)
  );

  rip_rr_arbiter_2 u_wr_rr (
    .clk       (clk),
    .rstn      (rstn),
    .req       ({S1.awvalid, S0.awvalid}),
    .update    (wr_upd),
    .upd_owner (wr_owner_reg),
    .grant     (wr_grant)
  );

  // Read and write state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_reg <= RD_IDLE;
      rd_owner_reg <= OWN_NONE;
      wr_state_reg <= WR_IDLE;
      wr_owner_reg <= OWN_NONE;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      wid_reg      <= '0;
    end else begin
      rd_state_reg <= rd_state_next;
      rd_owner_reg <= rd_owner_next;
      wr_state_reg <= wr_state_next;
      wr_owner_reg <= wr_owner_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
      wid_reg      <= wid_next;
    end
  end

  // Read FSM: grant in idle, wait for AR handshake, then hold until RLAST is accepted.
  always_comb begin
    rd_state_next = rd_state_reg;
    rd_owner_next = rd_owner_reg;
    rd_upd        = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        if (rd_grant != OWN_NONE) begin
          rd_state_next = RD_ADDR;
          rd_owner_next = rd_grant;
        end
      end
      RD_ADDR: begin
        if (M.arvalid && M.arready) begin
          rd_state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M.rvalid && M.rready && M.rlast) begin
          rd_state_next = RD_IDLE;
          rd_owner_next = OWN_NONE;
          rd_upd        = 1'b1;
        end
      end
      default: begin
        rd_state_next = RD_IDLE;
        rd_owner_next = OWN_NONE;
      end
    endcase
  end

  // Write FSM: AW and the last W beat may finish in either order; respond once both are done.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_owner_next = wr_owner_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    wid_next      = wid_reg;
    wr_upd        = 1'b0;
    case (wr_state_reg)
      WR_IDLE: begin
        if (wr_grant != OWN_NONE) begin
          wr_state_next = WR_XFER;
          wr_owner_next = wr_grant;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wid_next      = wr_grant[1] ? S1.awid : S0.awid;
        end
      end
      WR_XFER: begin
        if (M.awvalid && M.awready) begin
          aw_done_next = 1'b1;
        end
        if (M.wvalid && M.wready && M.wlast) begin
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          wr_state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M.bvalid && M.bready) begin
          wr_state_next = WR_IDLE;
          wr_owner_next = OWN_NONE;
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
          wr_upd        = 1'b1;
        end
      end
      default: begin
        wr_state_next = WR_IDLE;
        wr_owner_next = OWN_NONE;
        aw_done_next  = 1'b0;
        w_done_next   = 1'b0;
      end
    endcase
  end

  // AR/R routing: pass-through to and from the owner, everything else held at zero.
  always_comb begin
    M.arvalid  = 1'b0;
    M.arid     = '0;
    M.araddr   = {ADDR_WIDTH{1'b0}};
    M.arlen    = '0;
    M.arsize   = '0;
    M.arburst  = '0;
    M.rready   = 1'b0;
    S0.arready = 1'b0;
    S0.rvalid  = 1'b0;
    S0.rid     = '0;
    S0.rdata   = {DATA_WIDTH{1'b0}};
    S0.rresp   = '0;
    S0.rlast   = 1'b0;
    S1.arready = 1'b0;
    S1.rvalid  = 1'b0;
    S1.rid     = '0;
    S1.rdata   = {DATA_WIDTH{1'b0}};
    S1.rresp   = '0;
    S1.rlast   = 1'b0;
    if (rd_state_reg == RD_ADDR) begin
      M.arvalid  = rd_sel1 ? S1.arvalid : S0.arvalid;
      M.arid     = rd_sel1 ? S1.arid    : S0.arid;
      M.araddr   = rd_sel1 ? S1.araddr  : S0.araddr;
      M.arlen    = rd_sel1 ? S1.arlen   : S0.arlen;
      M.arsize   = rd_sel1 ? S1.arsize  : S0.arsize;
      M.arburst  = rd_sel1 ? S1.arburst : S0.arburst;
      S0.arready = !rd_sel1 && M.arready;
      S1.arready =  rd_sel1 && M.arready;
    end
    if (rd_state_reg == RD_DATA) begin
      M.rready = rd_sel1 ? S1.rready : S0.rready;
      if (rd_sel1) begin
        S1.rvalid = M.rvalid;
        S1.rid    = M.rid;
        S1.rdata  = M.rdata;
        S1.rresp  = M.rresp;
        S1.rlast  = M.rlast;
      end else begin
        S0.rvalid = M.rvalid;
        S0.rid    = M.rid;
        S0.rdata  = M.rdata;
        S0.rresp  = M.rresp;
        S0.rlast  = M.rlast;
      end
    end
  end

  // AW/W/B routing: AW and W are masked once their done flag is set so nothing is issued twice.
  always_comb begin
    M.awvalid  = 1'b0;
    M.awid     = '0;
    M.awaddr   = {ADDR_WIDTH{1'b0}};
    M.awlen    = '0;
    M.awsize   = '0;
    M.awburst  = '0;
    M.wvalid   = 1'b0;
    M.wid      = '0;
    M.wdata    = {DATA_WIDTH{1'b0}};
    M.wstrb    = '0;
    M.wlast    = 1'b0;
    M.bready   = 1'b0;
    S0.awready = 1'b0;
    S0.wready  = 1'b0;
    S0.bvalid  = 1'b0;
    S0.bid     = '0;
    S0.bresp   = '0;
    S1.awready = 1'b0;
    S1.wready  = 1'b0;
    S1.bvalid  = 1'b0;
    S1.bid     = '0;
    S1.bresp   = '0;
    if (wr_state_reg == WR_XFER) begin
      M.awvalid  = (wr_sel1 ? S1.awvalid : S0.awvalid) && !aw_done_reg;
      M.awid     = wr_sel1 ? S1.awid    : S0.awid;
      M.awaddr   = wr_sel1 ? S1.awaddr  : S0.awaddr;
      M.awlen    = wr_sel1 ? S1.awlen   : S0.awlen;
      M.awsize   = wr_sel1 ? S1.awsize  : S0.awsize;
      M.awburst  = wr_sel1 ? S1.awburst : S0.awburst;
      M.wvalid   = (wr_sel1 ? S1.wvalid : S0.wvalid) && !w_done_reg;
      M.wid      = wid_reg;
      M.wdata    = wr_sel1 ? S1.wdata : S0.wdata;
      M.wstrb    = wr_sel1 ? S1.wstrb : S0.wstrb;
      M.wlast    = wr_sel1 ? S1.wlast : S0.wlast;
      S0.awready = !wr_sel1 && M.awready && !aw_done_reg;
      S1.awready =  wr_sel1 && M.awready && !aw_done_reg;
      S0.wready  = !wr_sel1 && M.wready && !w_done_reg;
      S1.wready  =  wr_sel1 && M.wready && !w_done_reg;
    end
    if (wr_state_reg == WR_RESP) begin
      M.bready = wr_sel1 ? S1.bready : S0.bready;
      if (wr_sel1) begin
        S1.bvalid = M.bvalid;
        S1.bid    = M.bid;
        S1.bresp  = M.bresp;
      end else begin
        S0.bvalid = M.bvalid;
        S0.bid    = M.bid;
        S0.bresp  = M.bresp;
      end
    end
  end

endmodule

// File: tb/tb_rip_axi_arbiter.sv
// Directed bench for rip_axi_arbiter: requesters and downstream slave are driven by hand.
module tb_rip_axi_arbiter;
  import rip_axi_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rstn = 1'b0;
  owner_t rd_owner;
  owner_t wr_owner;
  int     total = 0;
  int     bad = 0;

  rip_axi_interface s0_if ();
  rip_axi_interface s1_if ();
  rip_axi_interface m_if ();

  rip_axi_arbiter dut (
    .clk      (clk),
    .rstn     (rstn),
    .S0       (s0_if),
    .S1       (s1_if),
    .M        (m_if),
    .rd_owner (rd_owner),
    .wr_owner (wr_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    s0_if.awid = '0; s0_if.awaddr = '0; s0_if.awlen = '0; s0_if.awsize = '0; s0_if.awburst = '0;
    s0_if.awvalid = 0; s0_if.wid = '0; s0_if.wdata = '0; s0_if.wstrb = '0; s0_if.wlast = 0;
    s0_if.wvalid = 0; s0_if.bready = 0; s0_if.arid = '0; s0_if.araddr = '0; s0_if.arlen = '0;
    s0_if.arsize = '0; s0_if.arburst = '0; s0_if.arvalid = 0; s0_if.rready = 0;
    s1_if.awid = '0; s1_if.awaddr = '0; s1_if.awlen = '0; s1_if.awsize = '0; s1_if.awburst = '0;
    s1_if.awvalid = 0; s1_if.wid = '0; s1_if.wdata = '0; s1_if.wstrb = '0; s1_if.wlast = 0;
    s1_if.wvalid = 0; s1_if.bready = 0; s1_if.arid = '0; s1_if.araddr = '0; s1_if.arlen = '0;
    s1_if.arsize = '0; s1_if.arburst = '0; s1_if.arvalid = 0; s1_if.rready = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bid = '0; m_if.bresp = '0; m_if.bvalid = 0;
    m_if.arready = 0; m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 0;
    m_if.rvalid = 0;
  endtask

  // Present (or drop) a read request on port p; ARID is 8 + port.
  task automatic set_ar(input int p, input logic v, input logic [31:0] addr, input logic [7:0] len);
    if (p == 0) begin
      s0_if.arvalid = v; s0_if.araddr = addr; s0_if.arlen = len; s0_if.arid = 4'h8; s0_if.rready = 1;
    end else begin
      s1_if.arvalid = v; s1_if.araddr = addr; s1_if.arlen = len; s1_if.arid = 4'h9; s1_if.rready = 1;
    end
  endtask

  // Called the cycle after the grant edge: finish AR and stream len+1 beats; err marks a SLVERR beat.
  task automatic rd_serve(input int p, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input int err);
    logic [3:0] id;
    logic [1:0] own;
    id  = 4'(8 + p);
    own = (p == 1) ? 2'b10 : 2'b01;
    check("rd_owner_grant", rd_owner, own);
    check("m_arvalid", m_if.arvalid, 1);
    check("m_araddr", m_if.araddr, addr);
    check("m_arlen", m_if.arlen, len);
    check("m_arid", m_if.arid, id);
    m_if.arready = 1;
    #1;
    check("own_arready", (p == 1) ? s1_if.arready : s0_if.arready, 1);
    check("oth_arready", (p == 1) ? s0_if.arready : s1_if.arready, 0);
    tick();
    if (p == 0) s0_if.arvalid = 0; else s1_if.arvalid = 0;
    m_if.arready = 0;
    for (int i = 0; i <= int'(len); i++) begin
      m_if.rvalid = 1;
      m_if.rdata  = base + 32'(i);
      m_if.rid    = id;
      m_if.rlast  = (i == int'(len));
      m_if.rresp  = (i == err) ? 2'b10 : 2'b00;
      #1;
      check("own_rvalid", (p == 1) ? s1_if.rvalid : s0_if.rvalid, 1);
      check("own_rdata", (p == 1) ? s1_if.rdata : s0_if.rdata, base + 32'(i));
      check("own_rresp", (p == 1) ? s1_if.rresp : s0_if.rresp, (i == err) ? 2'b10 : 2'b00);
      check("own_rlast", (p == 1) ? s1_if.rlast : s0_if.rlast, (i == int'(len)));
      check("oth_rvalid", (p == 1) ? s0_if.rvalid : s1_if.rvalid, 0);
      check("m_rready", m_if.rready, 1);
      check("rd_owner_hold", rd_owner, own);
      tick();
    end
    m_if.rvalid = 0; m_if.rlast = 0; m_if.rresp = 0;
    #1;
    check("rd_owner_idle", rd_owner, 0);
    check("m_arvalid_idle", m_if.arvalid, 0);
    $display("txn read port=%0d addr=%08h beats=%0d", p, addr, int'(len) + 1);
  endtask

  initial begin
    clear_all();
    #2;
    // Reset state
    check("rst_rd_owner", rd_owner, 0);
    check("rst_wr_owner", wr_owner, 0);
    check("rst_m_arvalid", m_if.arvalid, 0);
    check("rst_m_awvalid", m_if.awvalid, 0);
    check("rst_m_wvalid", m_if.wvalid, 0);
    check("rst_s0_arready", s0_if.arready, 0);
    check("rst_s1_bvalid", s1_if.bvalid, 0);
    tick(); tick();
    rstn = 1;

    // Single read from S0: 4 beats, grant visible one cycle after request
    set_ar(0, 1, 32'h1000, 8'd3);
    #1;
    check("single_not_yet", m_if.arvalid, 0);
    tick();
    rd_serve(0, 32'h1000, 8'd3, 32'hA0, -1);

    // Fresh reset so the tie is resolved from the reset pointer
    rstn = 0; tick(); rstn = 1; tick();
    set_ar(0, 1, 32'h1800, 8'd0);
    set_ar(1, 1, 32'h2000, 8'd0);
    tick();
    rd_serve(0, 32'h1800, 8'd0, 32'hB0, -1);
    tick();
    rd_serve(1, 32'h2000, 8'd0, 32'hB8, -1);
    // Lone S0 read moves the pointer to S0, so the next tie goes to S1
    set_ar(0, 1, 32'h1900, 8'd0);
    tick();
    rd_serve(0, 32'h1900, 8'd0, 32'hB4, -1);
    set_ar(0, 1, 32'h1A00, 8'd0);
    set_ar(1, 1, 32'h2100, 8'd0);
    tick();
    rd_serve(1, 32'h2100, 8'd0, 32'hBC, -1);
    tick();
    rd_serve(0, 32'h1A00, 8'd0, 32'hBE, -1);

    // Write from S1 with W accepted one cycle before AW
    s1_if.awvalid = 1; s1_if.awaddr = 32'h3000; s1_if.awid = 4'h5; s1_if.awlen = 0;
    s1_if.wvalid = 1; s1_if.wdata = 32'hDEADBEEF; s1_if.wstrb = 4'hF; s1_if.wlast = 1;
    s1_if.bready = 1; s0_if.bready = 1;
    tick();
    check("wr_owner_s1", wr_owner, 2'b10);
    check("wr_m_awvalid", m_if.awvalid, 1);
    check("wr_m_awaddr", m_if.awaddr, 32'h3000);
    check("wr_m_wvalid", m_if.wvalid, 1);
    check("wr_m_wdata", m_if.wdata, 32'hDEADBEEF);
    check("wr_m_wid", m_if.wid, 4'h5);
    m_if.wready = 1; m_if.awready = 0;
    #1;
    check("wr_s1_wready", s1_if.wready, 1);
    check("wr_s1_awready_lo", s1_if.awready, 0);
    check("wr_s0_wready", s0_if.wready, 0);
    tick();
    s1_if.wvalid = 0; m_if.wready = 0; m_if.awready = 1;
    #1;
    check("wr_s1_awready", s1_if.awready, 1);
    check("wr_owner_xfer", wr_owner, 2'b10);
    check("wr_s0_bvalid_a", s0_if.bvalid, 0);
    tick();
    s1_if.awvalid = 0; m_if.awready = 0;
    m_if.bvalid = 1; m_if.bid = 4'h5; m_if.bresp = 2'b00;
    #1;
    check("wr_m_awvalid_resp", m_if.awvalid, 0);
    check("wr_s1_bvalid", s1_if.bvalid, 1);
    check("wr_s1_bid", s1_if.bid, 4'h5);
    check("wr_s1_bresp", s1_if.bresp, 2'b00);
    check("wr_s0_bvalid_b", s0_if.bvalid, 0);
    check("wr_m_bready", m_if.bready, 1);
    tick();
    m_if.bvalid = 0;
    #1;
    check("wr_owner_idle", wr_owner, 0);
    $display("txn write port=1 addr=00003000 bresp=0");

    // Concurrent S0 write (2 beats) and S1 read (2 beats)
    s0_if.awvalid = 1; s0_if.awaddr = 32'h4000; s0_if.awid = 4'h6; s0_if.awlen = 1;
    s0_if.wvalid = 1; s0_if.wdata = 32'h11; s0_if.wstrb = 4'hF; s0_if.wlast = 0;
    set_ar(1, 1, 32'h5000, 8'd1);
    tick();
    check("cc_rd_owner", rd_owner, 2'b10);
    check("cc_wr_owner", wr_owner, 2'b01);
    m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
    #1;
    check("cc_m_araddr", m_if.araddr, 32'h5000);
    check("cc_m_awaddr", m_if.awaddr, 32'h4000);
    check("cc_m_wdata0", m_if.wdata, 32'h11);
    check("cc_s1_arready", s1_if.arready, 1);
    check("cc_s0_awready", s0_if.awready, 1);
    check("cc_s0_arready", s0_if.arready, 0);
    check("cc_s1_awready", s1_if.awready, 0);
    tick();
    s0_if.awvalid = 0; s1_if.arvalid = 0; m_if.arready = 0; m_if.awready = 0;
    s0_if.wdata = 32'h22; s0_if.wlast = 1;
    m_if.rvalid = 1; m_if.rdata = 32'h77; m_if.rid = 4'h9; m_if.rlast = 0;
    #1;
    check("cc_s1_rvalid0", s1_if.rvalid, 1);
    check("cc_s1_rdata0", s1_if.rdata, 32'h77);
    check("cc_s0_rvalid0", s0_if.rvalid, 0);
    check("cc_m_wdata1", m_if.wdata, 32'h22);
    check("cc_m_wlast", m_if.wlast, 1);
    tick();
    s0_if.wvalid = 0; m_if.wready = 0;
    m_if.rdata = 32'h78; m_if.rlast = 1;
    m_if.bvalid = 1; m_if.bid = 4'h6; m_if.bresp = 2'b11;
    #1;
    check("cc_s0_bvalid", s0_if.bvalid, 1);
    check("cc_s0_bresp", s0_if.bresp, 2'b11);
    check("cc_s1_bvalid", s1_if.bvalid, 0);
    check("cc_s1_rvalid1", s1_if.rvalid, 1);
    check("cc_s1_rdata1", s1_if.rdata, 32'h78);
    check("cc_s0_rvalid1", s0_if.rvalid, 0);
    tick();
    m_if.rvalid = 0; m_if.rlast = 0; m_if.bvalid = 0; m_if.bresp = 0;
    #1;
    check("cc_rd_idle", rd_owner, 0);
    check("cc_wr_idle", wr_owner, 0);
    $display("txn concurrent wr port=0 addr=00004000 rd port=1 addr=00005000");

    // SLVERR on beat 2 of a 4-beat burst is forwarded and grant holds until RLAST
    set_ar(0, 1, 32'h7000, 8'd3);
    tick();
    rd_serve(0, 32'h7000, 8'd3, 32'hC0, 1);

    // Reset during beat 2 of a read burst
    set_ar(0, 1, 32'h8000, 8'd3);
    tick();
    check("rb_grant", rd_owner, 2'b01);
    m_if.arready = 1;
    tick();
    s0_if.arvalid = 0; m_if.arready = 0;
    m_if.rvalid = 1; m_if.rdata = 32'hE0; m_if.rid = 4'h8;
    tick();
    m_if.rdata = 32'hE1;
    #1;
    check("rb_beat2_rvalid", s0_if.rvalid, 1);
    rstn = 0;
    #1;
    check("rb_rd_owner", rd_owner, 0);
    check("rb_s0_rvalid", s0_if.rvalid, 0);
    check("rb_s0_rdata", s0_if.rdata, 0);
    check("rb_m_rready", m_if.rready, 0);
    $display("txn reset mid-burst port=0 addr=00008000");
    m_if.rvalid = 0;
    tick(); tick();
    rstn = 1;
    set_ar(1, 1, 32'h6000, 8'd0);
    tick();
    rd_serve(1, 32'h6000, 8'd0, 32'hF0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
